// File: rtl/sensor_data_arbiter_pkg.sv
// rtl/sensor_data_arbiter_pkg.sv - shared state encodings and tx word layout for the sensor arbiter
package sensor_data_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_RELEASE = 2'd2,
    ST_SEND    = 2'd3
  } arb_state_t;

  localparam int NB_SENSORS_DEFAULT  = 4;
  localparam int DATA_WIDTH_DEFAULT  = 102;
  localparam int ACK_TIMEOUT_DEFAULT = 16;

  // tx word layout: iterations in the low bits, sensor id directly above them
  localparam int TX_ITER_LSB = 0;

  function automatic int id_width(input int nb_sensors);
    return (nb_sensors > 1) ? $clog2(nb_sensors) : 1;
  endfunction

  function automatic int tx_id_lsb(input int data_width);
    return TX_ITER_LSB + data_width;
  endfunction

  function automatic int tx_width(input int nb_sensors, input int data_width);
    return id_width(nb_sensors) + data_width;
  endfunction

endpackage

// File: rtl/sensor_data_arbiter_rr_picker.sv
// rtl/sensor_data_arbiter_rr_picker.sv - combinational round-robin picker: first request at or after rr_ptr
module rr_priority_picker #(
  parameter int NB_SENSORS = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic [NB_SENSORS-1:0] req,
  input  logic [ID_WIDTH-1:0]   rr_ptr,
  output logic [ID_WIDTH-1:0]   grant,
  output logic                  any_req
);

  logic [ID_WIDTH-1:0] idx;

  // Walk offsets from farthest to nearest so the closest request to rr_ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NB_SENSORS - 1; off >= 0; off--) begin
      idx = ID_WIDTH'((int'(rr_ptr) + off) % NB_SENSORS);
      if (req[idx]) begin
        grant = idx;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sensor_data_arbiter.sv
// rtl/sensor_data_arbiter.sv - shares one transmitter among per-photodiode data parsers
module sensor_data_arbiter
  import sensor_data_arbiter_pkg::*;
#(
  parameter int NB_SENSORS  = NB_SENSORS_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int ID_WIDTH    = id_width(NB_SENSORS),
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                             clk_72MHz,
  input  logic                             reset_n,
  input  logic [NB_SENSORS-1:0]            sensor_enable,
  input  logic [NB_SENSORS-1:0]            sensor_data_avl,
  input  logic [NB_SENSORS*DATA_WIDTH-1:0] sensor_iterations,
  output logic [NB_SENSORS-1:0]            reset_parser,
  output logic [ID_WIDTH+DATA_WIDTH-1:0]   tx_data,
  output logic                             tx_valid,
  input  logic                             tx_ready,
  output logic                             ack_timeout_err,
  output logic [ID_WIDTH-1:0]              err_sensor_id
);

  localparam int CNT_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int ID_LSB = tx_id_lsb(DATA_WIDTH);

  arb_state_t          state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] gnt;
  logic [CNT_W-1:0]    count;

  logic [NB_SENSORS-1:0] req;
  logic [ID_WIDTH-1:0]   pick;
  logic                  any_req;
  logic [ID_WIDTH-1:0]   gnt_next;
  logic [DATA_WIDTH-1:0] iter_words [NB_SENSORS];

  for (genvar i = 0; i < NB_SENSORS; i++) begin : g_unpack
    assign iter_words[i] = sensor_iterations[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Masking happens only here; a grant already taken is not revoked by sensor_enable.
  assign req = sensor_data_avl & sensor_enable;

  assign gnt_next = (int'(gnt) == NB_SENSORS - 1) ? '0 : gnt + ID_WIDTH'(1);

  rr_priority_picker #(
    .NB_SENSORS (NB_SENSORS),
    .ID_WIDTH   (ID_WIDTH)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .grant   (pick),
    .any_req (any_req)
  );

  always_ff @(posedge clk_72MHz or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      gnt             <= '0;
      count           <= '0;
      reset_parser    <= '0;
      tx_data         <= '0;
      tx_valid        <= 1'b0;
      ack_timeout_err <= 1'b0;
      err_sensor_id   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt   <= pick;
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          tx_data[ID_LSB +: ID_WIDTH]        <= gnt;
          tx_data[TX_ITER_LSB +: DATA_WIDTH] <= iter_words[gnt];
          reset_parser                       <= NB_SENSORS'(1) << gnt;
          count                              <= '0;
          state                              <= ST_RELEASE;
        end

        ST_RELEASE: begin
          count <= count + CNT_W'(1);
          if (!sensor_data_avl[gnt]) begin
            reset_parser <= '0;
            state        <= ST_SEND;
          end else if (count == CNT_W'(ACK_TIMEOUT - 1)) begin
            // Parser ignored the release; the word already latched still goes out.
            reset_parser    <= '0;
            ack_timeout_err <= 1'b1;
            err_sensor_id   <= gnt;
            state           <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
          end else if (tx_ready) begin
            tx_valid <= 1'b0;
            rr_ptr   <= gnt_next;
            state    <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
